// File: rtl/sys_ctrl_regs.sv
// ---------------------------------------------------------------------------
// sys_ctrl_pkg / sys_ctrl_regs
//
// System-control register slave on the peripheral link (window
// 0x0000_2000..0x0000_2FFF; only addr[11:0] is decoded).
// It owns per-domain clock enables and resets, the core boot addresses,
// the hart IDs, the PLL configuration words and four general-purpose
// registers. It also generates self-timed reset pulses, so software can
// restart a domain without holding the bus.
//
// Ports:
//   clk_i               system clock
//   arst_i              asynchronous reset, active-high
//   req_i               AXI-Lite request  (AW / W / B-ready / AR / R-ready)
//   resp_o              AXI-Lite response (readies, B and R channels)
//   clk_en_o[4:0]       clock enables: 0=e_core 1=p_core 2=core_link
//                       3=sys_link 4=periph_link
//   rst_o[4:0]          active-high domain resets, same bit order
//   boot_addr_*_o       E-core / P-core boot addresses
//   hartid_*_o          E-core / P-core hart IDs
//   pll_cfg_*_o         PLL configuration words
// ---------------------------------------------------------------------------
package sys_ctrl_pkg;

    localparam logic [31:0] SYS_CTRL_START = 32'h0000_2000;
    localparam logic [31:0] SYS_CTRL_END   = 32'h0000_2FFF;

    typedef struct packed {
        logic [31:0] aw_addr;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_valid;
        logic        b_ready;
        logic [31:0] ar_addr;
        logic        ar_valid;
        logic        r_ready;
    } pl_sc_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic [1:0]  b_resp;
        logic        ar_ready;
        logic        r_valid;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
    } pl_sc_resp_t;

endpackage

module sys_ctrl_regs
    import sys_ctrl_pkg::*;
#(
    parameter logic [31:0] E_CORE_BOOT_DEFAULT   = 32'h0900_0000,
    parameter logic [31:0] P_CORE_BOOT_DEFAULT   = 32'h0800_0000,
    parameter logic [31:0] E_CORE_HARTID_DEFAULT = 32'd0,
    parameter logic [31:0] P_CORE_HARTID_DEFAULT = 32'd1,
    parameter logic [31:0] PLL_CFG_DEFAULT       = 32'h0000_0001,
    parameter int          RST_PULSE_CYCLES      = 16
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  pl_sc_req_t  req_i,
    output pl_sc_resp_t resp_o,
    output logic [4:0]  clk_en_o,
    output logic [4:0]  rst_o,
    output logic [31:0] boot_addr_e_core_o,
    output logic [31:0] boot_addr_p_core_o,
    output logic [31:0] hartid_e_core_o,
    output logic [31:0] hartid_p_core_o,
    output logic [31:0] pll_cfg_e_core_o,
    output logic [31:0] pll_cfg_p_core_o,
    output logic [31:0] pll_cfg_sys_link_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] PULSE_LOAD  = 8'(RST_PULSE_CYCLES);

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CLK_RST,
        SEL_BOOT_E,
        SEL_BOOT_P,
        SEL_HART_E,
        SEL_HART_P,
        SEL_PLL_E,
        SEL_PLL_P,
        SEL_PLL_S,
        SEL_GPR
    } reg_sel_t;

    // Full 12-bit match, so misaligned offsets fall through to SEL_NONE.
    function automatic reg_sel_t decode(input logic [11:0] a);
        reg_sel_t sel;
        sel = SEL_NONE;
        case (a)
            12'h000, 12'h004, 12'h008, 12'h00C, 12'h010: sel = SEL_CLK_RST;
            12'h040: sel = SEL_BOOT_E;
            12'h044: sel = SEL_BOOT_P;
            12'h080: sel = SEL_HART_E;
            12'h084: sel = SEL_HART_P;
            12'h0C0: sel = SEL_PLL_E;
            12'h0C4: sel = SEL_PLL_P;
            12'h0CC: sel = SEL_PLL_S;
            12'hFF0, 12'hFF4, 12'hFF8, 12'hFFC: sel = SEL_GPR;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Register state
    logic [4:0]  clk_en_q;
    logic [4:0]  rst_q;
    logic [7:0]  pulse_cnt_q [5];
    logic [4:0]  pulse_pend_q;
    logic [4:0]  pulse_busy;
    logic [31:0] boot_e_q, boot_p_q;
    logic [31:0] hart_e_q, hart_p_q;
    logic [31:0] pll_e_q, pll_p_q, pll_s_q;
    logic [31:0] gpr_q [4];

    // Bus state
    logic        bus_up_q;
    logic        aw_held_q, w_held_q;
    logic [11:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        b_valid_q;
    logic [1:0]  b_resp_q;
    logic        r_valid_q;
    logic [31:0] r_data_q;
    logic [1:0]  r_resp_q;

    logic        aw_ready, w_ready, ar_ready;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_fire;
    reg_sel_t    wr_sel, rd_sel;
    logic [2:0]  wr_dom, rd_dom;
    logic [1:0]  wr_gpr, rd_gpr;
    logic [31:0] rd_data;
    logic        rd_err;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_i.aw_addr[31:12], req_i.ar_addr[31:12]};

    // Readies stay low until the first clock after reset, and the write side
    // stays closed from AW/W capture until the B handshake (one write in flight).
    assign aw_ready = bus_up_q & ~aw_held_q & ~b_valid_q;
    assign w_ready  = bus_up_q & ~w_held_q  & ~b_valid_q;
    assign ar_ready = bus_up_q & ~r_valid_q;

    assign aw_hs   = req_i.aw_valid & aw_ready;
    assign w_hs    = req_i.w_valid  & w_ready;
    assign ar_hs   = req_i.ar_valid & ar_ready;
    assign b_hs    = b_valid_q & req_i.b_ready;
    assign r_hs    = r_valid_q & req_i.r_ready;
    assign wr_fire = aw_held_q & w_held_q;

    assign wr_sel = decode(aw_addr_q);
    assign wr_dom = aw_addr_q[4:2];
    assign wr_gpr = aw_addr_q[3:2];
    assign rd_sel = decode(req_i.ar_addr[11:0]);
    assign rd_dom = req_i.ar_addr[4:2];
    assign rd_gpr = req_i.ar_addr[3:2];

    always_comb begin
        pulse_busy = '0;
        for (int d = 0; d < 5; d++) begin
            pulse_busy[d] = (pulse_cnt_q[d] != 8'd0);
        end
    end

    // Read data is looked up combinationally from the AR address and captured
    // at the AR handshake, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_sel)
            SEL_CLK_RST: rd_data = {29'd0, pulse_busy[rd_dom], rst_q[rd_dom], clk_en_q[rd_dom]};
            SEL_BOOT_E:  rd_data = boot_e_q;
            SEL_BOOT_P:  rd_data = boot_p_q;
            SEL_HART_E:  rd_data = hart_e_q;
            SEL_HART_P:  rd_data = hart_p_q;
            SEL_PLL_E:   rd_data = pll_e_q;
            SEL_PLL_P:   rd_data = pll_p_q;
            SEL_PLL_S:   rd_data = pll_s_q;
            SEL_GPR:     rd_data = gpr_q[rd_gpr];
            default:     rd_err  = 1'b1;
        endcase
    end

    // AXI-Lite handshake state: one-entry AW and W buffers, B issued the cycle
    // after both are held, R issued the cycle after AR.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            bus_up_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            bus_up_q <= 1'b1;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= req_i.aw_addr[11:0];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= req_i.w_data;
                w_strb_q <= req_i.w_strb;
            end
            if (wr_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                b_valid_q <= 1'b1;
                b_resp_q  <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                b_valid_q <= 1'b0;
            end
            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_data;
                r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    // Register file. A PULSE write is only remembered at commit; the counter
    // is loaded at the B handshake so the response always completes before the
    // reset asserts (matters for the periph_link domain that carries the bus).
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            clk_en_q     <= 5'b11101;
            rst_q        <= 5'b00010;
            pulse_pend_q <= '0;
            for (int d = 0; d < 5; d++) pulse_cnt_q[d] <= '0;
            boot_e_q     <= E_CORE_BOOT_DEFAULT;
            boot_p_q     <= P_CORE_BOOT_DEFAULT;
            hart_e_q     <= E_CORE_HARTID_DEFAULT;
            hart_p_q     <= P_CORE_HARTID_DEFAULT;
            pll_e_q      <= PLL_CFG_DEFAULT;
            pll_p_q      <= PLL_CFG_DEFAULT;
            pll_s_q      <= PLL_CFG_DEFAULT;
            for (int g = 0; g < 4; g++) gpr_q[g] <= '0;
        end else begin
            for (int d = 0; d < 5; d++) begin
                if (b_hs && pulse_pend_q[d]) begin
                    pulse_cnt_q[d] <= PULSE_LOAD;
                end else if (pulse_cnt_q[d] != 8'd0) begin
                    pulse_cnt_q[d] <= pulse_cnt_q[d] - 8'd1;
                end
            end
            if (b_hs) pulse_pend_q <= '0;
            if (wr_fire) begin
                case (wr_sel)
                    SEL_CLK_RST: begin
                        if (w_strb_q[0]) begin
                            clk_en_q[wr_dom] <= w_data_q[0];
                            rst_q[wr_dom]    <= w_data_q[1];
                            if (w_data_q[2]) pulse_pend_q[wr_dom] <= 1'b1;
                        end
                    end
                    SEL_BOOT_E: boot_e_q <= apply_strb(boot_e_q, w_data_q, w_strb_q);
                    SEL_BOOT_P: boot_p_q <= apply_strb(boot_p_q, w_data_q, w_strb_q);
                    SEL_HART_E: hart_e_q <= apply_strb(hart_e_q, w_data_q, w_strb_q);
                    SEL_HART_P: hart_p_q <= apply_strb(hart_p_q, w_data_q, w_strb_q);
                    SEL_PLL_E:  pll_e_q  <= apply_strb(pll_e_q,  w_data_q, w_strb_q);
                    SEL_PLL_P:  pll_p_q  <= apply_strb(pll_p_q,  w_data_q, w_strb_q);
                    SEL_PLL_S:  pll_s_q  <= apply_strb(pll_s_q,  w_data_q, w_strb_q);
                    SEL_GPR:    gpr_q[wr_gpr] <= apply_strb(gpr_q[wr_gpr], w_data_q, w_strb_q);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = aw_ready;
        resp_o.w_ready  = w_ready;
        resp_o.b_valid  = b_valid_q;
        resp_o.b_resp   = b_resp_q;
        resp_o.ar_ready = ar_ready;
        resp_o.r_valid  = r_valid_q;
        resp_o.r_data   = r_data_q;
        resp_o.r_resp   = r_resp_q;
    end

    assign clk_en_o           = clk_en_q;
    assign rst_o              = rst_q | pulse_busy;
    assign boot_addr_e_core_o = boot_e_q;
    assign boot_addr_p_core_o = boot_p_q;
    assign hartid_e_core_o    = hart_e_q;
    assign hartid_p_core_o    = hart_p_q;
    assign pll_cfg_e_core_o   = pll_e_q;
    assign pll_cfg_p_core_o   = pll_p_q;
    assign pll_cfg_sys_link_o = pll_s_q;

endmodule

// File: doc/sys_ctrl_regs.md
Name: sys_ctrl_regs

Overview:
AXI-Lite register slave behind the peripheral link. It consumes the pl_sc_req_t / pl_sc_resp_t port at SYS_CTRL_START..SYS_CTRL_END (0x0000_2000–0x0000_2FFF). It drives per-domain clock enables and resets, core boot addresses, hart IDs, PLL configuration words and four general-purpose registers. It also generates self-timed reset pulses so software can restart a domain without holding the bus.

Parameters:
E_CORE_BOOT_DEFAULT, 32'h0900_0000, reset value of BOOT_ADDR_E_CORE
P_CORE_BOOT_DEFAULT, 32'h0800_0000, reset value of BOOT_ADDR_P_CORE
E_CORE_HARTID_DEFAULT, 0, reset value of BOOT_HARTID_E_CORE
P_CORE_HARTID_DEFAULT, 1, reset value of BOOT_HARTID_P_CORE
PLL_CFG_DEFAULT, 32'h0000_0001, reset value of all three PLL_CFG registers
RST_PULSE_CYCLES, 16, length of a software-triggered reset pulse (2..255)

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
req_i  in  pl_sc_req_t  AXI-Lite request (32b addr, 32b data, 4b strb)
resp_o  out  pl_sc_resp_t  AXI-Lite response
clk_en_o  out  5  clock enables [0]=e_core [1]=p_core [2]=core_link [3]=sys_link [4]=periph_link
rst_o  out  5  active-high domain resets, same bit order
boot_addr_e_core_o  out  32  E-core boot address
boot_addr_p_core_o  out  32  P-core boot address
hartid_e_core_o  out  32  E-core hart ID
hartid_p_core_o  out  32  P-core hart ID
pll_cfg_e_core_o  out  32  PLL config word
pll_cfg_p_core_o  out  32  PLL config word
pll_cfg_sys_link_o  out  32  PLL config word

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_i is asynchronous, active-high; all flops clear on it.
- Decode uses addr[11:0] only. Offsets:
  - CLK_RST registers: 0x000, 0x004, 0x008, 0x00C, 0x010 for domains 0..4
  - BOOT_ADDR: 0x040, 0x044
  - BOOT_HARTID: 0x080, 0x084
  - PLL_CFG: 0x0C0, 0x0C4, 0x0CC
  - GPR_0..3: 0xFF0..0xFFC
- Any other offset, or addr[1:0]!=0: SLVERR (2'b10), rdata=0, no state change.
- CLK_RST layout:
  - bit0 CLK_EN (RW)
  - bit1 RST (RW level)
  - bit2 PULSE: write-1 starts a pulse; reads as 1 while the pulse counter is nonzero
  - bits31:3 read 0
- rst_o[d] = RST[d] | (pulse_cnt[d]!=0).
- Reset values:
  - CLK_EN = 5'b11101 (p_core gated); RST = 5'b00010 (p_core held).
  - So clk_en_o=5'b11101 and rst_o=5'b00010 during and after reset.
  - Pulse counters 0; boot/hartid/PLL at their parameters; GPRs 0.
  - resp_o: all valid/ready low. Ready rises the first cycle after arst_i deasserts.
- Pulse behaviour:
  - A PULSE write loads the counter with RST_PULSE_CYCLES; it decrements each cycle to 0.
  - rst_o is high exactly RST_PULSE_CYCLES cycles, starting the cycle after the B handshake.
  - A PULSE write while busy reloads the counter (extends the pulse).
  - A write with bit2=0 never clears a running pulse.
  - Domain 4 (periph_link) pulses are legal: the B response completes before rst_o[4] asserts.
- Write channel:
  - AW and W are accepted independently, one-entry buffer each; aw_ready is low while AW is held, same for W.
  - When both are held: the register updates with byte strobes and B is issued the next cycle.
  - bvalid stays high until bready; a new AW/W is accepted only after the B handshake (one outstanding write).
  - Strobe 4'b0000 is a legal no-op with OKAY.
- Read channel:
  - ar_ready is high when no read is outstanding.
  - rvalid is asserted 1 cycle after the AR handshake and held until rready.
  - rdata is sampled at the AR handshake.
- Simultaneous read and write to the same register in one cycle: read returns the pre-write value.
- Read and write channels are independent; no ordering between them.
- rresp/bresp: OKAY (2'b00) or SLVERR only; never DECERR.
- A reset mid-transaction drops the transaction: no B or R after reset.

Test Plan:
- Reset then read 0x000..0x010 -> rdata 0x1,0x2,0x1,0x1,0x1 OKAY; clk_en_o=5'b11101, rst_o=5'b00010.
- Write 0x004=0x1, then read 0x044 -> rst_o[1]=0, clk_en_o[1]=1; rdata=0x0800_0000.
- Write 0x000=0x5 (CLK_EN|PULSE) -> rst_o[0] high exactly 16 cycles after B; read 0x000 mid-pulse = 0x5, after = 0x1.
- Write GPR_2 (0xFF8)=0xDEAD_BEEF strb=4'b0011, then read -> 0x0000_BEEF; W presented 3 cycles before AW -> single B, OKAY.
- Read 0x050 and write 0x0C8 -> SLVERR, rdata 0, no output change; read 0x041 -> SLVERR.
- Back-pressure: bready/rready held low 5 cycles -> bvalid/rvalid stay high with stable payload; no second AW or AR accepted; assert arst_i mid-B -> bvalid drops, outputs return to reset values.
